// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states and the
// default-width command record.
package counter_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STEP_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD
  } seq_state_e;

  typedef struct packed {
    cmd_op_e             op;
    logic [WIDTH-1:0]    data;
    logic [STEP_W-1:0]   steps;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module cmd_fifo import counter_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = cmd_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  logic   [AW:0]   wr_ptr_q;
  logic   [AW:0]   rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer driving an up/down counter's load_n/ce/up_down/data_load pins.
// Define COUNTER_CMD_SEQ_SAT_STOP_EN to stop counts at max_count/zero instead of wrapping.
module counter_cmd_seq #(
  parameter int unsigned WIDTH      = counter_pkg::WIDTH,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  counter_pkg::cmd_op_e cmd_op,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic [STEP_W-1:0]    cmd_steps,
  output logic                 load_n,
  output logic                 ce,
  output logic                 up_down,
  output logic [WIDTH-1:0]     data_load,
  input  logic                 max_count,
  input  logic                 zero,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  import counter_pkg::*;

  typedef struct packed {
    cmd_op_e            op;
    logic [WIDTH-1:0]   data;
    logic [STEP_W-1:0]  steps;
  } cmd_entry_t;

  cmd_entry_t        push_entry;
  cmd_entry_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              load_n_q, load_n_d;
  logic              ce_q, ce_d;
  logic              up_down_q, up_down_d;
  logic [WIDTH-1:0]  data_load_q, data_load_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;
  logic              stop;
  logic              last_step;

  assign push_entry = '{op: cmd_op, data: cmd_data, steps: cmd_steps};
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;

  cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (cmd_entry_t)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
  // Counter already at the limit it is heading for: suppress this enable.
  assign stop = (state_q == RUN) && ce_q && (up_down_q ? max_count : zero);
`else
  logic unused_flags;
  assign unused_flags = max_count ^ zero;
  assign stop         = 1'b0;
`endif

  assign last_step = stop || (step_cnt_q <= STEP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_cnt_q  <= '0;
      load_n_q    <= 1'b1;
      ce_q        <= 1'b0;
      up_down_q   <= 1'b0;
      data_load_q <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      load_n_q    <= load_n_d;
      ce_q        <= ce_d;
      up_down_q   <= up_down_d;
      data_load_q <= data_load_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          step_cnt_d = head.steps;
          unique case (head.op)
            OP_LOAD:        state_d = LOAD;
            OP_UP, OP_DOWN: state_d = RUN;
            OP_HOLD:        state_d = HOLD;
          endcase
        end
      end
      LOAD: state_d = IDLE;
      RUN, HOLD: begin
        if (last_step) state_d    = IDLE;
        else           step_cnt_d = step_cnt_q - STEP_W'(1);
      end
    endcase
  end

  // Registered pin values for the next cycle, aligned with state_d.
  always_comb begin
    load_n_d    = 1'b1;
    ce_d        = 1'b0;
    up_down_d   = up_down_q;
    data_load_d = data_load_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          sat_d = 1'b0;
          unique case (head.op)
            OP_LOAD: begin
              load_n_d    = 1'b0;
              data_load_d = head.data;
            end
            OP_UP, OP_DOWN: begin
              ce_d      = (head.steps != '0);
              up_down_d = (head.op == OP_UP);
            end
            OP_HOLD: ;
          endcase
        end
      end
      LOAD: done_d = 1'b1;
      RUN: begin
        if (last_step) done_d = 1'b1;
        else           ce_d   = 1'b1;
        if (stop)      sat_d  = 1'b1;
      end
      HOLD: begin
        if (last_step) done_d = 1'b1;
      end
    endcase
  end

  assign load_n    = load_n_q;
  assign ce        = ce_q && !stop;
  assign up_down   = up_down_q;
  assign data_load = data_load_q;
  assign done      = done_q;
  assign sat       = sat_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq with a behavioural 4-bit up/down counter
// closing the loop on max_count/zero.
module tb_counter_cmd_seq;
  import counter_pkg::*;

  localparam int unsigned W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  cmd_op_e       cmd_op = OP_LOAD;
  logic [W-1:0]  cmd_data = '0;
  logic [7:0]    cmd_steps = '0;
  logic          load_n, ce, up_down, busy, done, sat;
  logic [W-1:0]  data_load;
  logic          max_count, zero;
  logic [W-1:0]  count = '0;

  int n_cmp = 0;
  int n_err = 0;
  int ce_cnt = 0, up_cnt = 0, down_cnt = 0, load_cnt = 0, done_cnt = 0;
  int ready_low_cnt = 0, busy_cnt = 0, run_len = 0, last_run = 0;
  logic [W-1:0] last_load = '0;

  always #5 clk = ~clk;

  counter_cmd_seq #(
    .WIDTH      (W),
    .STEP_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .max_count (max_count),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .sat       (sat)
  );

  // Behavioural counter: synchronous load has priority over count enable.
  always @(posedge clk) begin
    if (!load_n)  count <= data_load;
    else if (ce)  count <= up_down ? count + 1'b1 : count - 1'b1;
  end
  assign max_count = (count == 4'hF);
  assign zero      = (count == 4'h0);

  // Pin activity monitor, sampled mid-cycle; tests read it after a rising edge.
  always @(negedge clk) begin
    if (ce) begin
      ce_cnt++;
      if (up_down) up_cnt++; else down_cnt++;
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (!load_n) begin
      load_cnt++;
      last_load = data_load;
    end
    if (done)       done_cnt++;
    if (!cmd_ready) ready_low_cnt++;
    if (busy)       busy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_cmd(input cmd_op_e op, input logic [W-1:0] d, input logic [7:0] s);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_steps = s;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (!cmd_ready) begin
      n_err++;
      $display("FAIL push_ready: cmd_ready got %b, required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (busy) begin
      n_err++;
      $display("FAIL wait_idle: busy got %b, required 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (load_n !== 1'b1) begin n_err++; $display("FAIL reset_load_n: got %b, required 1", load_n); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b, required 0", ce); end
    n_cmp++; if (up_down !== 1'b0) begin n_err++; $display("FAIL reset_up_down: got %b, required 0", up_down); end
    n_cmp++; if (data_load !== 4'h0) begin n_err++; $display("FAIL reset_data_load: got %h, required 0", data_load); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b, required 0", sat); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    int l0 = load_cnt;
    int d0 = done_cnt;
    @(negedge clk);
    push_cmd(OP_LOAD, 4'hA, 8'd0);
    wait_idle();
    n_cmp++; if (load_cnt - l0 != 1) begin n_err++; $display("FAIL load_cycles: got %0d, required 1", load_cnt - l0); end
    n_cmp++; if (last_load !== 4'hA) begin n_err++; $display("FAIL load_data: got %h, required a", last_load); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL load_done: got %0d, required 1", done_cnt - d0); end
    n_cmp++; if (count !== 4'hA) begin n_err++; $display("FAIL load_count: got %h, required a", count); end
  endtask

  task automatic test_count_up();
    int u0 = up_cnt;
    int n0 = down_cnt;
    int d0 = done_cnt;
    @(negedge clk);
    push_cmd(OP_LOAD, 4'h3, 8'd0);
    push_cmd(OP_UP, 4'h0, 8'd5);
    wait_idle();
    n_cmp++; if (up_cnt - u0 != 5) begin n_err++; $display("FAIL up_ce: got %0d, required 5", up_cnt - u0); end
    n_cmp++; if (down_cnt - n0 != 0) begin n_err++; $display("FAIL up_down_ce: got %0d, required 0", down_cnt - n0); end
    n_cmp++; if (last_run != 5) begin n_err++; $display("FAIL up_run_len: got %0d, required 5", last_run); end
    n_cmp++; if (done_cnt - d0 != 2) begin n_err++; $display("FAIL up_done: got %0d, required 2", done_cnt - d0); end
    n_cmp++; if (count !== 4'h8) begin n_err++; $display("FAIL up_count: got %h, required 8", count); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL up_sat: got %b, required 0", sat); end
  endtask

  task automatic test_count_down();
    int n0 = down_cnt;
    int d0 = done_cnt;
    int exp_ce;
    logic [W-1:0] exp_count;
    logic exp_sat;
`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
    exp_ce = 2; exp_count = 4'h0; exp_sat = 1'b1;
`else
    exp_ce = 4; exp_count = 4'hE; exp_sat = 1'b0;
`endif
    @(negedge clk);
    push_cmd(OP_LOAD, 4'h2, 8'd0);
    push_cmd(OP_DOWN, 4'h0, 8'd4);
    wait_idle();
    n_cmp++; if (down_cnt - n0 != exp_ce) begin n_err++; $display("FAIL down_ce: got %0d, required %0d", down_cnt - n0, exp_ce); end
    n_cmp++; if (last_run != exp_ce) begin n_err++; $display("FAIL down_run_len: got %0d, required %0d", last_run, exp_ce); end
    n_cmp++; if (done_cnt - d0 != 2) begin n_err++; $display("FAIL down_done: got %0d, required 2", done_cnt - d0); end
    n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL down_count: got %h, required %h", count, exp_count); end
    n_cmp++; if (sat !== exp_sat) begin n_err++; $display("FAIL down_sat: got %b, required %b", sat, exp_sat); end
  endtask

  // A long HOLD first so the following four commands fill the FIFO.
  task automatic test_back_to_back();
    int d0 = done_cnt;
    int u0 = up_cnt;
    int n0 = down_cnt;
    int l0 = load_cnt;
    int r0 = ready_low_cnt;
    int b0 = busy_cnt;
    @(negedge clk);
    push_cmd(OP_HOLD, 4'h0, 8'd8);
    push_cmd(OP_LOAD, 4'h5, 8'd0);
    push_cmd(OP_UP, 4'h0, 8'd3);
    push_cmd(OP_HOLD, 4'h0, 8'd0);
    push_cmd(OP_DOWN, 4'h0, 8'd1);
    wait_idle();
    n_cmp++; if (ready_low_cnt - r0 != 6) begin n_err++; $display("FAIL b2b_ready_low: got %0d, required 6", ready_low_cnt - r0); end
    n_cmp++; if (busy_cnt - b0 != 19) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d, required 19", busy_cnt - b0); end
    n_cmp++; if (done_cnt - d0 != 5) begin n_err++; $display("FAIL b2b_done: got %0d, required 5", done_cnt - d0); end
    n_cmp++; if (load_cnt - l0 != 1) begin n_err++; $display("FAIL b2b_load: got %0d, required 1", load_cnt - l0); end
    n_cmp++; if (last_load !== 4'h5) begin n_err++; $display("FAIL b2b_load_data: got %h, required 5", last_load); end
    n_cmp++; if (up_cnt - u0 != 3) begin n_err++; $display("FAIL b2b_up_ce: got %0d, required 3", up_cnt - u0); end
    n_cmp++; if (down_cnt - n0 != 1) begin n_err++; $display("FAIL b2b_down_ce: got %0d, required 1", down_cnt - n0); end
    n_cmp++; if (count !== 4'h7) begin n_err++; $display("FAIL b2b_count: got %h, required 7", count); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL b2b_sat: got %b, required 0", sat); end
  endtask

  task automatic test_reset_mid_run();
    int d0 = done_cnt;
    @(negedge clk);
    push_cmd(OP_UP, 4'h0, 8'd10);
    repeat (3) @(negedge clk);
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL midrun_ce_before: got %b, required 1", ce); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL midrun_ce_reset: got %b, required 0", ce); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy_reset: got %b, required 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrun_ready_reset: got %b, required 1", cmd_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL midrun_no_done: got %0d, required 0", done_cnt - d0); end
    @(negedge clk);
    push_cmd(OP_LOAD, 4'h9, 8'd0);
    wait_idle();
    n_cmp++; if (count !== 4'h9) begin n_err++; $display("FAIL midrun_after_count: got %h, required 9", count); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL midrun_after_done: got %0d, required 1", done_cnt - d0); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL midrun_after_sat: got %b, required 0", sat); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_count_up();
    test_count_down();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
